// File: rtl/dmi_lock_pkg.sv
// Shared types for the password-gated JTAG DMI front end: op/error codes, FSM states and
// the default-width request layout.
package dmi_lock_pkg;

  typedef enum logic [1:0] {
    OpNop   = 2'd0,
    OpRead  = 2'd1,
    OpWrite = 2'd2,
    OpPass  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    ErrOk     = 2'd0,
    ErrDenied = 2'd2,
    ErrBusy   = 2'd3
  } dmi_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StWaitRead,
    StWaitWrite,
    StHashReq,
    StHashWait
  } state_e;

  localparam int unsigned DefAbitsW = 7;
  localparam int unsigned DefDataW  = 32;

  typedef struct packed {
    logic [DefAbitsW-1:0] addr;
    logic [DefDataW-1:0]  data;
    dmi_op_e              op;
  } dmi_req_t;

  // A capture in these states would return stale data, so it reports busy instead.
  function automatic logic capture_busy(state_e s);
    return s inside {StRead, StWaitRead, StWaitWrite, StHashReq, StHashWait};
  endfunction

endpackage

// File: rtl/dmi_pass_buf.sv
// Password word buffer: PassWords x DataW, written by index, cleared as a whole,
// exposed as one flat message with word 0 in the LSBs.
module dmi_pass_buf #(
  parameter int unsigned  PassWords = 2,
  parameter int unsigned  DataW     = 32,
  localparam int unsigned IdxW      = (PassWords > 1) ? $clog2(PassWords) : 1
) (
  input  logic                       tck_i,
  input  logic                       trst_ni,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [IdxW-1:0]            i_idx,
  input  logic [DataW-1:0]           i_wdata,
  output logic [PassWords*DataW-1:0] o_msg
);

  logic [PassWords-1:0][DataW-1:0] r_words;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_words <= '0;
    end else if (i_clr) begin
      r_words <= '0;
    end else if (i_we) begin
      for (int unsigned i = 0; i < PassWords; i++) begin
        if (i_idx == IdxW'(i)) begin
          r_words[i] <= i_wdata;
        end
      end
    end
  end

  assign o_msg = r_words;

endmodule

// File: rtl/dmi_jtag_lock.sv
// JTAG-side DMI front end: DR shift register, op decode, request/response FSM and a
// password unlock path that hashes assembled words externally and locks out after MaxFails.
module dmi_jtag_lock
  import dmi_lock_pkg::*;
#(
  parameter int unsigned  AbitsW    = 7,
  parameter int unsigned  DataW     = 32,
  parameter int unsigned  PassWords = 2,
  parameter int unsigned  HashW     = 256,
  parameter int unsigned  MaxFails  = 3,
  localparam int unsigned DrW       = AbitsW + DataW + 2
) (
  input  logic                       tck_i,
  input  logic                       trst_ni,
  input  logic                       test_logic_reset_i,
  input  logic                       capture_dr_i,
  input  logic                       shift_dr_i,
  input  logic                       update_dr_i,
  input  logic                       dmi_access_i,
  input  logic                       dtmcs_select_i,
  input  logic                       dmi_reset_i,
  input  logic                       dmi_tdi_i,
  output logic                       dmi_tdo_o,
  output logic [1:0]                 dmi_error_o,
  input  logic                       read_lock_i,
  output logic [DrW-1:0]             req_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  input  logic [DataW-1:0]           resp_data_i,
  input  logic                       resp_valid_i,
  output logic                       resp_ready_o,
  output logic                       hash_start_o,
  input  logic                       hash_ready_i,
  output logic [PassWords*DataW-1:0] hash_msg_o,
  input  logic                       hash_valid_i,
  input  logic [HashW-1:0]           hash_i,
  input  logic [HashW-1:0]           exp_hash_i,
  output logic                       unlocked_o,
  output logic                       lockout_o
);

  localparam int unsigned IdxW  = (PassWords > 1) ? $clog2(PassWords) : 1;
  localparam int unsigned FailW = $clog2(MaxFails + 1);

  logic [DrW-1:0]    r_dr;
  logic [AbitsW-1:0] r_addr;
  logic [DataW-1:0]  r_data;
  logic [1:0]        r_error;
  logic [IdxW-1:0]   r_word_cnt;
  logic [FailW-1:0]  r_fail_cnt;
  state_e            r_state;
  logic              r_req_valid;
  logic [1:0]        r_req_op;
  logic              r_hash_start;
  logic              r_unlocked;
  logic              r_lockout;

  logic [AbitsW-1:0] w_dr_addr;
  logic [DataW-1:0]  w_dr_data;
  dmi_op_e           w_dr_op;
  logic              w_update, w_capture, w_decode, w_busy, w_dmi_clear;
  logic [1:0]        w_cap_err;
  logic              w_go_read, w_go_write, w_pass_wr, w_relock, w_denied;
  logic              w_last_word, w_fail_last, w_hash_match, w_buf_clr;

  assign w_dr_addr    = r_dr[DrW-1 -: AbitsW];
  assign w_dr_data    = r_dr[DataW+1:2];
  assign w_dr_op      = dmi_op_e'(r_dr[1:0]);
  assign w_update     = update_dr_i && dmi_access_i;
  assign w_capture    = capture_dr_i && dmi_access_i;
  assign w_decode     = w_update && (r_state == StIdle) && (r_error == ErrOk);
  assign w_busy       = (w_update && (r_state != StIdle)) || (w_capture && capture_busy(r_state));
  assign w_dmi_clear  = dmi_reset_i && dtmcs_select_i;
  assign w_cap_err    = w_busy ? 2'(ErrBusy) : r_error;
  assign w_last_word  = (r_word_cnt == IdxW'(PassWords - 1));
  assign w_fail_last  = (r_fail_cnt >= FailW'(MaxFails - 1));
  assign w_hash_match = (hash_i == exp_hash_i);
  assign w_buf_clr    = w_relock || ((r_state == StHashWait) && hash_valid_i);

  always_comb begin
    w_go_read  = 1'b0;
    w_go_write = 1'b0;
    w_pass_wr  = 1'b0;
    w_relock   = 1'b0;
    w_denied   = 1'b0;
    if (w_decode) begin
      case (w_dr_op)
        OpRead: begin
          if (r_unlocked || !read_lock_i) w_go_read = 1'b1;
          else                            w_denied  = 1'b1;
        end
        OpWrite: begin
          if (r_unlocked) w_go_write = 1'b1;
          else            w_denied   = 1'b1;
        end
        // All-ones address is the relock command rather than a password word.
        OpPass: begin
          if (&w_dr_addr)     w_relock  = 1'b1;
          else if (r_lockout) w_denied  = 1'b1;
          else                w_pass_wr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  dmi_pass_buf #(
    .PassWords (PassWords),
    .DataW     (DataW)
  ) u_pass_buf (
    .tck_i   (tck_i),
    .trst_ni (trst_ni),
    .i_clr   (w_buf_clr),
    .i_we    (w_pass_wr),
    .i_idx   (r_word_cnt),
    .i_wdata (w_dr_data),
    .o_msg   (hash_msg_o)
  );

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_dr         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_error      <= ErrOk;
      r_word_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_state      <= StIdle;
      r_req_valid  <= 1'b0;
      r_req_op     <= OpNop;
      r_hash_start <= 1'b0;
      r_unlocked   <= 1'b0;
      r_lockout    <= 1'b0;
    end else begin
      if (test_logic_reset_i)             r_dr <= '0;
      else if (w_capture)                 r_dr <= {r_addr, r_data, w_cap_err};
      else if (shift_dr_i && dmi_access_i) r_dr <= {dmi_tdi_i, r_dr[DrW-1:1]};

      if (w_dmi_clear)   r_error <= ErrOk;
      else if (w_busy)   r_error <= ErrBusy;
      else if (w_denied) r_error <= ErrDenied;

      if (w_decode) begin
        r_addr <= w_dr_addr;
        r_data <= w_dr_data;
      end

      if (w_relock)       r_word_cnt <= '0;
      else if (w_pass_wr) r_word_cnt <= w_last_word ? '0 : r_word_cnt + IdxW'(1);

      case (r_state)
        StIdle: begin
          if (w_go_read || w_go_write) begin
            r_state     <= w_go_read ? StRead : StWrite;
            r_req_op    <= w_go_read ? OpRead : OpWrite;
            r_req_valid <= 1'b1;
          end else if (w_pass_wr && w_last_word) begin
            r_state      <= StHashReq;
            r_hash_start <= 1'b1;
          end
          if (w_relock) r_unlocked <= 1'b0;
        end
        StRead, StWrite: begin
          if (req_ready_i) begin
            r_state     <= (r_state == StRead) ? StWaitRead : StWaitWrite;
            r_req_valid <= 1'b0;
            r_req_op    <= OpNop;
          end
        end
        StWaitRead, StWaitWrite: begin
          if (resp_valid_i) begin
            if (r_state == StWaitRead) r_data <= resp_data_i;
            r_state <= StIdle;
          end
        end
        StHashReq: begin
          if (hash_ready_i) begin
            r_hash_start <= 1'b0;
            r_state      <= StHashWait;
          end
        end
        StHashWait: begin
          if (hash_valid_i) begin
            if (w_hash_match) begin
              r_unlocked <= 1'b1;
              r_fail_cnt <= '0;
            end else begin
              r_fail_cnt <= w_fail_last ? FailW'(MaxFails) : r_fail_cnt + FailW'(1);
              if (w_fail_last) begin
                r_lockout  <= 1'b1;
                r_unlocked <= 1'b0;
              end
            end
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dmi_tdo_o    = r_dr[0];
  assign dmi_error_o  = r_error;
  assign req_o        = {r_addr, r_data, r_req_op};
  assign req_valid_o  = r_req_valid;
  assign resp_ready_o = 1'b1;
  assign hash_start_o = r_hash_start;
  assign unlocked_o   = r_unlocked;
  assign lockout_o    = r_lockout;

endmodule

// File: tb/tb_dmi_jtag_lock.sv
// Bench for dmi_jtag_lock: directed vector table, hand-written corner sequences and random
// transactions, all checked against a transaction-level model of the lock rules.
module tb_dmi_jtag_lock;

  localparam int unsigned AbitsW    = 7;
  localparam int unsigned DataW     = 32;
  localparam int unsigned PassWords = 2;
  localparam int unsigned HashW     = 256;
  localparam int unsigned MaxFails  = 3;
  localparam int unsigned DrW       = AbitsW + DataW + 2;
  localparam int unsigned NVec      = 18;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  logic tlr = 1'b0, capture = 1'b0, shift = 1'b0, update = 1'b0, dmi_access = 1'b0;
  logic dtmcs_sel = 1'b0, dmi_reset = 1'b0, tdi = 1'b0, read_lock = 1'b0;
  logic req_ready = 1'b0, resp_valid = 1'b0, hash_ready = 1'b0, hash_valid = 1'b0;
  logic [DataW-1:0] resp_data = '0;
  logic [HashW-1:0] hash_in = '0, exp_hash = '0;
  logic tdo, req_valid, resp_ready, hash_start, unlocked, lockout;
  logic [1:0] dmi_error;
  logic [DrW-1:0] req;
  logic [PassWords*DataW-1:0] hash_msg;

  always #5 tck = ~tck;

  dmi_jtag_lock #(
    .AbitsW    (AbitsW),
    .DataW     (DataW),
    .PassWords (PassWords),
    .HashW     (HashW),
    .MaxFails  (MaxFails)
  ) dut (
    .tck_i              (tck),
    .trst_ni            (trst_n),
    .test_logic_reset_i (tlr),
    .capture_dr_i       (capture),
    .shift_dr_i         (shift),
    .update_dr_i        (update),
    .dmi_access_i       (dmi_access),
    .dtmcs_select_i     (dtmcs_sel),
    .dmi_reset_i        (dmi_reset),
    .dmi_tdi_i          (tdi),
    .dmi_tdo_o          (tdo),
    .dmi_error_o        (dmi_error),
    .read_lock_i        (read_lock),
    .req_o              (req),
    .req_valid_o        (req_valid),
    .req_ready_i        (req_ready),
    .resp_data_i        (resp_data),
    .resp_valid_i       (resp_valid),
    .resp_ready_o       (resp_ready),
    .hash_start_o       (hash_start),
    .hash_ready_i       (hash_ready),
    .hash_msg_o         (hash_msg),
    .hash_valid_i       (hash_valid),
    .hash_i             (hash_in),
    .exp_hash_i         (exp_hash),
    .unlocked_o         (unlocked),
    .lockout_o          (lockout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: lock state, sticky error and the pending password words.
  bit                m_unl, m_lock;
  int                m_fails;
  logic [1:0]        m_err;
  logic [AbitsW-1:0] m_addr;
  logic [DataW-1:0]  m_data;
  logic [DataW-1:0]  m_words[$];

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  a;
    logic [31:0] d;
    logic        rl;
    logic        hok;
    logic [31:0] resp;
    logic [1:0]  e_err;
    logic        e_unl;
    logic        e_lock;
  } vec_t;

  vec_t tab [NVec];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_unl = 0; m_lock = 0; m_fails = 0; m_err = 2'd0; m_addr = '0; m_data = '0;
    m_words.delete();
  endtask

  task automatic model_hash(input logic hok);
    if (hok) begin
      m_unl = 1; m_fails = 0;
    end else begin
      if (m_fails < MaxFails) m_fails++;
      if (m_fails >= MaxFails) begin m_lock = 1; m_unl = 0; end
    end
    m_words.delete();
  endtask

  task automatic do_reset();
    @(negedge tck);
    trst_n = 1'b0;
    #2;
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_lockout", lockout, 1'b0);
    check("rst_error", dmi_error, 2'd0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_hash_start", hash_start, 1'b0);
    check("rst_resp_ready", resp_ready, 1'b1);
    check("rst_tdo", tdo, 1'b0);
    model_reset();
    @(negedge tck);
    trst_n = 1'b1;
  endtask

  task automatic clear_err();
    @(negedge tck);
    dmi_reset = 1'b1; dtmcs_sel = 1'b1;
    @(negedge tck);
    dmi_reset = 1'b0; dtmcs_sel = 1'b0;
    m_err = 2'd0;
    check("err_clear", dmi_error, 2'd0);
  endtask

  task automatic scan(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                      output logic [DrW-1:0] cap);
    logic [DrW-1:0] v;
    v = {a, d, op};
    @(negedge tck);
    dmi_access = 1'b1; capture = 1'b1;
    @(negedge tck);
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < DrW; i++) begin
      cap[i] = tdo;
      tdi = v[i];
      @(negedge tck);
    end
    shift = 1'b0; update = 1'b1;
    @(negedge tck);
    update = 1'b0; dmi_access = 1'b0;
  endtask

  // One DMI scan from IDLE; with fin set, the resulting request or hash is completed.
  task automatic run_txn(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                         input logic rl, input logic hok, input logic [31:0] resp,
                         input bit fin);
    logic [DrW-1:0] cap, exp_cap;
    logic [PassWords*DataW-1:0] msg;
    int kind;
    exp_cap = {m_addr, m_data, m_err};
    kind = 0;
    msg = '0;
    if (m_err == 2'd0) begin
      m_addr = a; m_data = d;
      case (op)
        2'd1: if (m_unl || !rl) kind = 1; else m_err = 2'd2;
        2'd2: if (m_unl) kind = 2; else m_err = 2'd2;
        2'd3: begin
          if (a == 7'h7F) begin
            m_unl = 0; m_words.delete();
          end else if (m_lock) begin
            m_err = 2'd2;
          end else begin
            m_words.push_back(d);
            if (m_words.size() == PassWords) kind = 3;
          end
        end
        default: ;
      endcase
    end
    for (int i = 0; i < m_words.size(); i++) msg[DataW*i +: DataW] = m_words[i];
    read_lock = rl;
    scan(op, a, d, cap);
    check("capture", cap, exp_cap);
    check("req_valid", req_valid, (kind == 1 || kind == 2));
    check("hash_start", hash_start, (kind == 3));
    check("error", dmi_error, m_err);
    if (kind == 1 || kind == 2) begin
      check("req", req, {a, d, (kind == 1) ? 2'd1 : 2'd2});
      if (fin) begin
        repeat ($urandom_range(0, 2)) @(negedge tck);
        req_ready = 1'b1;
        @(negedge tck);
        req_ready = 1'b0;
        check("req_done", req_valid, 1'b0);
        resp_data = resp; resp_valid = 1'b1;
        @(negedge tck);
        resp_valid = 1'b0;
        if (kind == 1) m_data = resp;
      end
    end else if (kind == 3) begin
      check("hash_msg", hash_msg, msg);
      if (fin) begin
        repeat ($urandom_range(1, 3)) @(negedge tck);
        check("hash_hold", hash_start, 1'b1);
        hash_ready = 1'b1;
        @(negedge tck);
        hash_ready = 1'b0;
        check("hash_taken", hash_start, 1'b0);
        hash_in = hok ? exp_hash : exp_hash ^ (256'h1 << $urandom_range(0, HashW - 1));
        hash_valid = 1'b1;
        @(negedge tck);
        hash_valid = 1'b0;
        model_hash(hok);
      end
    end
    if (fin) begin
      check("unlocked", unlocked, m_unl);
      check("lockout", lockout, m_lock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_hash = {8{32'hDEADBEEF}} ^ {HashW{1'b0}};
    exp_hash[17:0] = 18'h2A5C3;
    model_reset();
    //              op     a      d             rl    hok   resp          err   unl   lock
    tab[0]  = '{2'd1, 7'h10, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 2'd0, 1'b0, 1'b0};
    tab[1]  = '{2'd0, 7'h00, 32'h0,        1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[2]  = '{2'd2, 7'h04, 32'h1,        1'b0, 1'b0, 32'h0,        2'd2, 1'b0, 1'b0};
    tab[3]  = '{2'd3, 7'h00, 32'h11111111, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[4]  = '{2'd3, 7'h01, 32'h22222222, 1'b0, 1'b1, 32'h0,        2'd0, 1'b1, 1'b0};
    tab[5]  = '{2'd2, 7'h04, 32'h1,        1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0};
    tab[6]  = '{2'd1, 7'h10, 32'h0,        1'b1, 1'b0, 32'h12345678, 2'd0, 1'b1, 1'b0};
    tab[7]  = '{2'd3, 7'h7F, 32'h0,        1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[8]  = '{2'd1, 7'h10, 32'h0,        1'b1, 1'b0, 32'h0,        2'd2, 1'b0, 1'b0};
    tab[9]  = '{2'd3, 7'h00, 32'hAAAA0000, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[10] = '{2'd3, 7'h00, 32'hAAAA0001, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[11] = '{2'd3, 7'h00, 32'hBBBB0000, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[12] = '{2'd3, 7'h00, 32'hBBBB0001, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[13] = '{2'd3, 7'h00, 32'hCCCC0000, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0};
    tab[14] = '{2'd3, 7'h00, 32'hCCCC0001, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1};
    tab[15] = '{2'd3, 7'h00, 32'h1,        1'b0, 1'b0, 32'h0,        2'd2, 1'b0, 1'b1};
    tab[16] = '{2'd1, 7'h20, 32'h0,        1'b0, 1'b0, 32'h5A5A5A5A, 2'd0, 1'b0, 1'b1};
    tab[17] = '{2'd3, 7'h7F, 32'h0,        1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1};

    do_reset();

    for (int i = 0; i < NVec; i++) begin
      run_txn(tab[i].op, tab[i].a, tab[i].d, tab[i].rl, tab[i].hok, tab[i].resp, 1'b1);
      check($sformatf("tab%0d_err", i), dmi_error, tab[i].e_err);
      check($sformatf("tab%0d_unl", i), unlocked, tab[i].e_unl);
      check($sformatf("tab%0d_lock", i), lockout, tab[i].e_lock);
      if (m_err != 2'd0) clear_err();
    end

    // Lockout survives everything but trst_ni.
    do_reset();
    check("post_rst_lockout", lockout, 1'b0);

    // Busy: update while the read is outstanding, then same-cycle clear beats busy.
    run_txn(2'd1, 7'h11, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    req_ready = 1'b1;
    @(negedge tck);
    req_ready = 1'b0;
    dmi_access = 1'b1; update = 1'b1;
    @(negedge tck);
    dmi_access = 1'b0; update = 1'b0;
    check("busy_err", dmi_error, 2'd3);
    resp_data = 32'h600DF00D; resp_valid = 1'b1;
    @(negedge tck);
    resp_valid = 1'b0;
    m_data = 32'h600DF00D;
    m_err = 2'd3;
    run_txn(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    clear_err();
    run_txn(2'd1, 7'h12, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    req_ready = 1'b1;
    @(negedge tck);
    req_ready = 1'b0;
    dmi_access = 1'b1; update = 1'b1; dmi_reset = 1'b1; dtmcs_sel = 1'b1;
    @(negedge tck);
    dmi_access = 1'b0; update = 1'b0; dmi_reset = 1'b0; dtmcs_sel = 1'b0;
    check("clear_beats_busy", dmi_error, 2'd0);
    resp_data = 32'h0BADCAFE; resp_valid = 1'b1;
    @(negedge tck);
    resp_valid = 1'b0;
    m_data = 32'h0BADCAFE;

    // Reset in HASH_WAIT while unlocked; the late hash result must not unlock.
    run_txn(2'd3, 7'h00, 32'h13572468, 1'b0, 1'b0, 32'h0, 1'b1);
    run_txn(2'd3, 7'h00, 32'h24681357, 1'b0, 1'b1, 32'h0, 1'b1);
    run_txn(2'd3, 7'h00, 32'h01010101, 1'b0, 1'b0, 32'h0, 1'b1);
    run_txn(2'd3, 7'h00, 32'h02020202, 1'b0, 1'b1, 32'h0, 1'b0);
    hash_ready = 1'b1;
    @(negedge tck);
    hash_ready = 1'b0;
    #2;
    trst_n = 1'b0;
    #1;
    check("mid_hash_start", hash_start, 1'b0);
    check("mid_hash_unl", unlocked, 1'b0);
    model_reset();
    @(negedge tck);
    trst_n = 1'b1;
    hash_in = exp_hash; hash_valid = 1'b1;
    @(negedge tck);
    hash_valid = 1'b0;
    @(negedge tck);
    check("late_hash_unl", unlocked, 1'b0);
    run_txn(2'd1, 7'h05, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    clear_err();

    for (int it = 0; it < 60; it++) begin
      logic [1:0] op;
      logic [6:0] a;
      if (m_lock && $urandom_range(0, 2) == 0) do_reset();
      if (m_err != 2'd0) clear_err();
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3 && $urandom_range(0, 7) != 0) a = 7'($urandom_range(0, 126));
      else a = 7'($urandom);
      run_txn(op, a, $urandom, 1'($urandom), ($urandom_range(0, 3) != 0), $urandom, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
